// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the block-RAM backed memory-port responder.
package mem_port_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BUSY    = 2'd2,
        ST_REFRESH = 2'd3
    } state_e;

    localparam logic [31:0] OOR_PATTERN_DEFAULT = 32'hDEADBEEF;
    localparam int unsigned ADDR_EXT_W          = 64;

    // True when no address bit at or above depth_log2 is set.
    function automatic logic addr_in_range(input logic [ADDR_EXT_W-1:0] addr,
                                           input int unsigned            depth_log2);
        logic [ADDR_EXT_W-1:0] hi;
        hi = addr >> depth_log2;
        return (hi == {ADDR_EXT_W{1'b0}});
    endfunction

endpackage

// File: rtl/mem_port_store.sv
// Single-port synchronous RAM, write-first, no reset so it maps onto block RAM.
module mem_port_store #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Output register holds its value between enabled cycles.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-client port responder emulating DRAM timing (init stall, access
// latency, periodic refresh) on top of an on-chip RAM.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH       = 18,
    parameter int unsigned           DATA_WIDTH       = 32,
    parameter int unsigned           MEM_DEPTH_LOG2   = 10,
    parameter int unsigned           ACCESS_LATENCY   = 2,
    parameter int unsigned           INIT_CYCLES      = 16,
    parameter int unsigned           REFRESH_INTERVAL = 780,
    parameter int unsigned           REFRESH_CYCLES   = 8,
    parameter logic [DATA_WIDTH-1:0] OOR_PATTERN      = DATA_WIDTH'(OOR_PATTERN_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] data_write,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  pause,
    output logic                  controller_ready,
    output logic                  read_error
);

    localparam int unsigned IW = $clog2(INIT_CYCLES) + 1;
    localparam int unsigned LW = $clog2(ACCESS_LATENCY) + 1;
    localparam int unsigned RW = $clog2(REFRESH_INTERVAL) + 1;
    localparam int unsigned CW = $clog2(REFRESH_CYCLES) + 1;

    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(ACCESS_LATENCY - 1);
    localparam logic [RW-1:0] RI_LOAD   = RW'(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RC_LOAD   = CW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    state_e                state_q, state_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic [LW-1:0]         lat_cnt_q, lat_cnt_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [CW-1:0]         rc_cnt_q, rc_cnt_d;
    logic                  due_q, due_d;
    logic                  op_read_q, op_read_d;
    logic                  op_oor_q, op_oor_d;
    logic                  ready_q, ready_d;
    logic                  pause_q;
    logic                  read_error_q, read_error_d;
    logic [DATA_WIDTH-1:0] data_read_q, data_read_d;

    logic                  accept_s;
    logic                  ref_set_s;
    logic                  ref_clr_s;
    logic                  in_range_s;
    logic                  ram_we_s;
    logic [ADDR_EXT_W-1:0] addr_ext_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // Zero-extend the client address for the range helper.
    always_comb begin
        addr_ext_s                 = {ADDR_EXT_W{1'b0}};
        addr_ext_s[ADDR_WIDTH-1:0] = address;
        in_range_s                 = addr_in_range(addr_ext_s, MEM_DEPTH_LOG2);
    end

    // Out-of-range writes never reach the RAM; reads still cycle it harmlessly.
    assign ram_we_s = accept_s & wren & in_range_s;

    mem_port_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_store (
        .clk     (clk),
        .en_i    (accept_s),
        .we_i    (ram_we_s),
        .addr_i  (address[MEM_DEPTH_LOG2-1:0]),
        .wdata_i (data_write),
        .rdata_o (ram_rdata_s)
    );

    // Next-state logic for the access/refresh sequencer and its counters.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        ref_cnt_d    = ref_cnt_q;
        rc_cnt_d     = rc_cnt_q;
        op_read_d    = op_read_q;
        op_oor_d     = op_oor_q;
        ready_d      = ready_q;
        data_read_d  = data_read_q;
        read_error_d = 1'b0;
        accept_s     = 1'b0;
        ref_set_s    = 1'b0;
        ref_clr_s    = 1'b0;

        if (state_q != ST_INIT) begin
            if ((ref_cnt_q == RW'(0)) || (ref_cnt_q == RW'(1))) begin
                ref_cnt_d = RI_LOAD;
                ref_set_s = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q - RW'(1);
            end
        end else begin
            ref_cnt_d = ref_cnt_q;
        end

        case (state_q)
            ST_INIT: begin
                if ((init_cnt_q == IW'(0)) || (init_cnt_q == IW'(1))) begin
                    init_cnt_d = IW'(0);
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q - IW'(1);
                end
            end
            ST_IDLE: begin
                accept_s  = 1'b1;
                op_read_d = ~wren;
                op_oor_d  = ~in_range_s;
                lat_cnt_d = LAT_LOAD;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                if (lat_cnt_q == LW'(0)) begin
                    if (op_read_q) begin
                        data_read_d = op_oor_q ? OOR_PATTERN : ram_rdata_s;
                    end else begin
                        data_read_d = data_read_q;
                    end
                    read_error_d = op_oor_q;
                    // A pending refresh is taken straight after the access, keeping pause high.
                    if (due_q) begin
                        state_d   = ST_REFRESH;
                        rc_cnt_d  = RC_LOAD;
                        ref_clr_s = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end
            ST_REFRESH: begin
                if (rc_cnt_q == CW'(0)) begin
                    state_d  = ST_IDLE;
                end else begin
                    rc_cnt_d = rc_cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (ref_set_s) begin
            due_d = 1'b1;
        end else if (ref_clr_s) begin
            due_d = 1'b0;
        end else begin
            due_d = due_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= INIT_LOAD;
            lat_cnt_q    <= LW'(0);
            ref_cnt_q    <= RI_LOAD;
            rc_cnt_q     <= CW'(0);
            due_q        <= 1'b0;
            op_read_q    <= 1'b0;
            op_oor_q     <= 1'b0;
            ready_q      <= 1'b0;
            pause_q      <= 1'b1;
            read_error_q <= 1'b0;
            data_read_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            rc_cnt_q     <= rc_cnt_d;
            due_q        <= due_d;
            op_read_q    <= op_read_d;
            op_oor_q     <= op_oor_d;
            ready_q      <= ready_d;
            pause_q      <= (state_d != ST_IDLE);
            read_error_q <= read_error_d;
            data_read_q  <= data_read_d;
        end
    end

    assign data_read        = data_read_q;
    assign pause            = pause_q;
    assign controller_ready = ready_q;
    assign read_error       = read_error_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench for mem_port_responder (REFRESH_INTERVAL=40).
module tb_mem_port_responder;

    localparam int L  = 2;
    localparam int R  = 8;
    localparam int RI = 40;
    localparam int IC = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [17:0] address;
    logic        wren;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        pause;
    logic        ready;
    logic        read_error;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_mem [0:1023];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_port_responder #(
        .ADDR_WIDTH       (18),
        .DATA_WIDTH       (32),
        .MEM_DEPTH_LOG2   (10),
        .ACCESS_LATENCY   (L),
        .INIT_CYCLES      (IC),
        .REFRESH_INTERVAL (RI),
        .REFRESH_CYCLES   (R),
        .OOR_PATTERN      (32'hDEADBEEF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .address          (address),
        .wren             (wren),
        .data_write       (data_write),
        .data_read        (data_read),
        .pause            (pause),
        .controller_ready (ready),
        .read_error       (read_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (pause !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) check_eq(tag, 32'(pause), 32'd0);
    endtask

    // Called at a negedge; one access accepted at the next posedge.
    task automatic do_acc(input logic we, input logic [17:0] a, input logic [31:0] d,
                          output int lat, output logic err_before, output logic err_at,
                          output logic [31:0] dr_at);
        int i;
        bit done;
        wait_idle("wait_idle");
        address    = a;
        wren       = we;
        data_write = d;
        @(posedge clk);
        lat = 0; i = 0; done = 0;
        err_before = 1'b0; err_at = 1'b0; dr_at = 32'd0;
        while (!done) begin
            @(negedge clk);
            i++;
            if (i == L) err_before = read_error;
            if (i == L + 1) begin
                err_at = read_error;
                dr_at  = data_read;
            end
            if (pause) lat++;
            else done = 1;
            if (i >= 60) done = 1;
        end
        if (i < L + 1) begin
            err_at = read_error;
            dr_at  = data_read;
        end
    endtask

    task automatic chk_lat(input int lat, input bit strict);
        if (strict) check_eq("lat_strict", 32'(lat), 32'(L));
        else        check_eq("lat_ok", 32'((lat == L) || (lat == L + R)), 32'd1);
    endtask

    task automatic wr(input logic [17:0] a, input logic [31:0] d, input bit oor, input bit strict);
        int lat; logic eb, ea; logic [31:0] dr;
        do_acc(1'b1, a, d, lat, eb, ea, dr);
        chk_lat(lat, strict);
        check_eq("wr_data_read_held", dr, last_rd);
        check_eq("wr_err_pulse", 32'(ea), 32'(oor));
        check_eq("wr_err_early", 32'(eb), 32'd0);
        if (!oor) exp_mem[a[9:0]] = d;
    endtask

    task automatic rd(input logic [17:0] a, input logic [31:0] exp, input bit oor, input bit strict);
        int lat; logic eb, ea; logic [31:0] dr;
        do_acc(1'b0, a, 32'd0, lat, eb, ea, dr);
        chk_lat(lat, strict);
        check_eq("rd_data", dr, exp);
        check_eq("rd_err_pulse", 32'(ea), 32'(oor));
        check_eq("rd_err_early", 32'(eb), 32'd0);
        last_rd = exp;
    endtask

    // Called just after reset_n is released, away from a posedge.
    task automatic run_init();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 8) check_eq("init_ready_low", 32'(ready), 32'd0);
        end while (pause && n < 100);
        check_eq("init_cycles", 32'(n), 32'(IC));
        check_eq("init_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi, lo, bad, nlong, last_long, gap_bad, start;
        reset_n    = 1'b0;
        address    = 18'd0;
        wren       = 1'b0;
        data_write = 32'd0;
        last_rd    = 32'd0;

        #50;
        check_eq("rst_pause", 32'(pause), 32'd1);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_data_read", data_read, 32'd0);
        check_eq("rst_read_error", 32'(read_error), 32'd0);
        #50;
        reset_n = 1'b1;
        run_init();

        // Basic write then read, well before the first refresh.
        wr(18'd5, 32'h12345678, 1'b0, 1'b1);
        rd(18'd5, 32'h12345678, 1'b0, 1'b1);

        for (int a = 1; a <= 20; a++)
            wr(18'(a), {16'hC0DE, 8'(a), 8'(a) ^ 8'h5A}, 1'b0, 1'b0);
        for (int a = 1; a <= 20; a++)
            rd(18'(a), {16'hC0DE, 8'(a), 8'(a) ^ 8'h5A}, 1'b0, 1'b0);

        wr(18'h003FF, 32'hFEEDFACE, 1'b0, 1'b0);
        rd(18'h003FF, 32'hFEEDFACE, 1'b0, 1'b0);

        wr(18'h00000, 32'h0BADF00D, 1'b0, 1'b0);
        wr(18'h00400, 32'hFFFFFFFF, 1'b1, 1'b0);
        rd(18'h00000, 32'h0BADF00D, 1'b0, 1'b0);
        rd(18'h00400, 32'hDEADBEEF, 1'b1, 1'b0);
        rd(18'h20005, 32'hDEADBEEF, 1'b1, 1'b0);
        rd(18'd5, exp_mem[5], 1'b0, 1'b0);

        // Continuous reads: pause runs must be L or L+R, single idle cycles between.
        address = 18'd5;
        wren    = 1'b0;
        hi = 0; lo = 0; bad = 0; nlong = 0; last_long = -1; gap_bad = 0; start = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if (pause) begin
                if (hi == 0) start = i;
                hi++;
                if (lo > 1) bad++;
                lo = 0;
            end else begin
                if (hi > 0) begin
                    if (hi == L + R) begin
                        nlong++;
                        if (last_long >= 0 &&
                            ((start - last_long) < RI - (L + 1) || (start - last_long) > RI + (L + 1)))
                            gap_bad++;
                        last_long = start;
                    end else if (hi != L) begin
                        bad++;
                    end
                end
                hi = 0;
                lo++;
            end
        end
        check_eq("rf_run_shapes", 32'(bad), 32'd0);
        check_eq("rf_spacing", 32'(gap_bad), 32'd0);
        check_eq("rf_count", 32'(nlong >= 3), 32'd1);
        check_eq("rf_data", data_read, exp_mem[5]);
        last_rd = exp_mem[5];

        // Reset while a read is in BUSY.
        wait_idle("wait_idle_rst");
        address = 18'd5;
        wren    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("busy_before_rst", 32'(pause), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst2_pause", 32'(pause), 32'd1);
        check_eq("rst2_ready", 32'(ready), 32'd0);
        check_eq("rst2_data_read", data_read, 32'd0);
        check_eq("rst2_read_error", 32'(read_error), 32'd0);
        last_rd = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_init();
        rd(18'd5, exp_mem[5], 1'b0, 1'b1);
        rd(18'h003FF, 32'hFEEDFACE, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
